sdpram_fwd_clr: RTL and testbench

Parametrised simple dual-port RAM: one write port with byte strobes, and one read port that can return several consecutive entries per access. It adds a configurable same-cycle write-to-read forwarding mode, a read-valid pipeline for latency 1 or 2, and output hold while reads are idle. A self-clearing sweep after reset zeroes the array. It is the behavioural successor used by predictor tables, tag arrays and TLB storage that need a deterministic zero state without an external init pass.

---
 rtl/sdpram_fwd_clr.sv | 137 +++++++++++++
 tb/tb_sdpram_fwd_clr.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_fwd_clr.sv
// Simple dual-port RAM with byte-strobed writes, multi-entry line reads,
// optional write-first forwarding, 1/2-cycle read latency and a post-reset zero sweep.
module sdpram_fwd_clr #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1024,
    parameter int READ_MUL       = 1,
    parameter int LATENCY        = 1,
    parameter int FORWARD        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   we,
    input  logic [$clog2(RAM_DEPTH)-1:0]           waddr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]       wstrb,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    input  logic                                   re,
    input  logic [$clog2(RAM_DEPTH/READ_MUL)-1:0]  raddr,
    output logic [READ_MUL*DATA_WIDTH-1:0]         rdata,
    output logic                                   rvalid,
    output logic                                   busy
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int LW = $clog2(READ_MUL);
    localparam int SW = DATA_WIDTH / BYTE_WIDTH;
    localparam int LDW = READ_MUL * DATA_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         clr_ptr_q, clr_ptr_d;
    logic                  clr_we;
    logic                  run, wr_en, rd_en, line_hit;
    logic [DATA_WIDTH-1:0] wr_new;
    logic [LDW-1:0]        rd_line;
    logic                  out_vld;
    logic [LDW-1:0]        out_data;
    logic [LDW-1:0]        rdata_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [SW-1:0]         strb
    );
        merge_bytes = old_v;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) merge_bytes[i*BYTE_WIDTH +: BYTE_WIDTH] = new_v[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == AW'(RAM_DEPTH - 1)) state_d = RUN;
            end
            default: ;
        endcase
    end

    // Port activity is squashed both while sweeping and in the cycle rst is sampled.
    assign run   = (state_q == RUN) && !rst;
    assign wr_en = run && we;
    assign rd_en = run && re;
    assign busy  = (state_q == CLEAR);

    always_comb begin
        wr_new   = merge_bytes(mem_q[waddr], wdata, wstrb);
        line_hit = ((waddr >> LW) == AW'(raddr));
        rd_line  = '0;
        for (int k = 0; k < READ_MUL; k++) begin
            logic [AW-1:0]         idx;
            logic [DATA_WIDTH-1:0] ent;
            idx = (AW'(raddr) << LW) | AW'(k);
            ent = mem_q[idx];
            if ((FORWARD != 0) && wr_en && line_hit && ((waddr & AW'(READ_MUL - 1)) == AW'(k)))
                ent = wr_new;
            rd_line[k*DATA_WIDTH +: DATA_WIDTH] = ent;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we && !rst) mem_q[clr_ptr_q] <= '0;
        else if (wr_en)     mem_q[waddr]     <= wr_new;
    end

    // Stage 1: line capture (only materialised for two-cycle latency)
    generate
        if (LATENCY == 1) begin : g_lat1
            assign out_vld  = rd_en;
            assign out_data = rd_line;
        end else begin : g_lat2
            logic           vld_p1_q;
            logic [LDW-1:0] data_p1_q;
            always_ff @(posedge clk) begin
                if (rst) vld_p1_q <= 1'b0;
                else     vld_p1_q <= rd_en;
                if (rd_en) data_p1_q <= rd_line;
            end
            assign out_vld  = vld_p1_q;
            assign out_data = data_p1_q;
        end
    endgenerate

    // Output stage: holds last returned line between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= out_vld;
            if (out_vld) rdata_q <= out_data;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sdpram_fwd_clr.sv
// Scoreboard bench: DUT A is write-first/latency 2, DUT B is read-first/latency 1,
// both two-entry lines over a 16-entry array, sharing one stimulus stream.
module tb_sdpram_fwd_clr;

    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [3:0]  waddr, wstrb;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, busy_a, busy_b;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    logic [31:0] model [16];

    typedef struct {
        logic [63:0] d;
        int          due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdpram_fwd_clr #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(16), .READ_MUL(2),
        .LATENCY(2), .FORWARD(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a)
    );

    sdpram_fwd_clr #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(16), .READ_MUL(2),
        .LATENCY(1), .FORWARD(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
    );

    // Read-return monitors: every rvalid must match the oldest expected entry on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid_a === 1'b1) begin
                vectors++;
                if (qa.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_a: unexpected rvalid at cycle %0d, rdata=%h", cyc, rdata_a);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    if (e.due != cyc || rdata_a !== e.d) begin
                        miscompares++;
                        $display("FAIL read_a: cycle %0d got %h, expected %h at cycle %0d", cyc, rdata_a, e.d, e.due);
                    end
                end
            end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL read_a: missing rvalid at cycle %0d, expected %h", cyc, qa[0].d);
                void'(qa.pop_front());
            end
            if (rvalid_b === 1'b1) begin
                vectors++;
                if (qb.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_b: unexpected rvalid at cycle %0d, rdata=%h", cyc, rdata_b);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    if (e.due != cyc || rdata_b !== e.d) begin
                        miscompares++;
                        $display("FAIL read_b: cycle %0d got %h, expected %h at cycle %0d", cyc, rdata_b, e.d, e.due);
                    end
                end
            end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL read_b: missing rvalid at cycle %0d, expected %h", cyc, qb[0].d);
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        merge = o;
        for (int i = 0; i < 4; i++) if (s[i]) merge[i*8 +: 8] = n[i*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // One cycle of port activity; expectations derive from the reference array before it is updated.
    task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic r, input logic [2:0] ra);
        logic [63:0] pre, post;
        logic [31:0] nv;
        exp_t        e;
        nv   = merge(model[wa], wd, ws);
        pre  = {model[{ra, 1'b1}], model[{ra, 1'b0}]};
        post = pre;
        if (w && wa[3:1] == ra) post[wa[0]*32 +: 32] = nv;
        we = w; waddr = wa; wdata = wd; wstrb = ws; re = r; raddr = ra;
        if (r) begin
            e.d = post; e.due = cyc + 2; qa.push_back(e);
            e.d = pre;  e.due = cyc + 1; qb.push_back(e);
        end
        if (w) model[wa] = nv;
        step();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic drain();
        repeat (4) step();
        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending reads a=%0d b=%0d, required 0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic read_all();
        for (int l = 0; l < 8; l++) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 3'(l));
        drain();
    endtask

    // Counts busy cycles starting at the next falling edge; leaves the bench just after a rising edge.
    task automatic sweep(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (busy_a !== 1'b1 || busy_b !== 1'b1) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 32'hC0DE0000 + 32'(i * 17), 4'hF, 1'b0, 3'h0);
        read_all();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        vectors++;
        if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: a=%h b=%h, required 0", rdata_a, rdata_b);
        end
        vectors++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctrl: rvalid a=%b b=%b busy a=%b b=%b, required rvalid 0 busy 1",
                     rvalid_a, rvalid_b, busy_a, busy_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep(n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL reset_sweep_len: busy for %0d cycles, required 16", n);
        end
        zero_model();
        read_all();
    endtask

    task automatic test_byte_strobe();
        drive(1'b1, 4'd5, 32'hAABBCCDD, 4'b1111, 1'b0, 3'd0);
        drive(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0, 3'd0);
        drive(1'b1, 4'd4, 32'h55667788, 4'b0000, 1'b0, 3'd0);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 3'd2);
        drain();
        vectors++;
        if (rdata_a !== {32'hAA22CC44, 32'h0} || rdata_b !== {32'hAA22CC44, 32'h0}) begin
            miscompares++;
            $display("FAIL byte_strobe: a=%h b=%h, required %h", rdata_a, rdata_b, {32'hAA22CC44, 32'h0});
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 4'd6, 32'h0, 4'hF, 1'b0, 3'd0);
        drive(1'b1, 4'd7, 32'h12345678, 4'hF, 1'b0, 3'd0);
        drive(1'b1, 4'd7, 32'hFFFF0000, 4'b1100, 1'b1, 3'd3);
        drain();
        vectors++;
        if (rdata_a !== {32'hFFFF5678, 32'h0}) begin
            miscompares++;
            $display("FAIL collision_fwd: got %h, required %h", rdata_a, {32'hFFFF5678, 32'h0});
        end
        vectors++;
        if (rdata_b !== {32'h12345678, 32'h0}) begin
            miscompares++;
            $display("FAIL collision_rdfirst: got %h, required %h", rdata_b, {32'h12345678, 32'h0});
        end
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 3'd3);
        drain();
        vectors++;
        if (rdata_b !== {32'hFFFF5678, 32'h0}) begin
            miscompares++;
            $display("FAIL collision_next: got %h, required %h", rdata_b, {32'hFFFF5678, 32'h0});
        end
        // Write to the other lane of a different line must not disturb a colliding read.
        drive(1'b1, 4'd2, 32'hA5A5A5A5, 4'hF, 1'b1, 3'd7);
        drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'd2, 32'h01020304, 4'hF, 1'b0, 3'd0);
        drive(1'b1, 4'd14, 32'hBEEF0001, 4'hF, 1'b0, 3'd0);
        drive(1'b1, 4'd15, 32'hBEEF0002, 4'hF, 1'b0, 3'd0);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 3'd1);
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 3'd7);
        repeat (6) step();
        @(negedge clk);
        vectors++;
        if (rvalid_a !== 1'b0 || rdata_a !== {32'hBEEF0002, 32'hBEEF0001}) begin
            miscompares++;
            $display("FAIL hold_a: rvalid=%b rdata=%h, required 0 and %h", rvalid_a, rdata_a,
                     {32'hBEEF0002, 32'hBEEF0001});
        end
        vectors++;
        if (rvalid_b !== 1'b0 || rdata_b !== {32'hBEEF0002, 32'hBEEF0001}) begin
            miscompares++;
            $display("FAIL hold_b: rvalid=%b rdata=%h, required 0 and %h", rvalid_b, rdata_b,
                     {32'hBEEF0002, 32'hBEEF0001});
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_mid_read();
        int   n;
        exp_t e;
        re = 1'b1; raddr = 3'd7;
        e.d = {model[15], model[14]}; e.due = cyc + 1; qb.push_back(e);
        step();
        re = 1'b0;
        rst = 1'b1;
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        step();
        rst = 1'b0; we = 1'b0;
        @(negedge clk);
        vectors++;
        if (rvalid_a !== 1'b0 || rdata_a !== 64'h0 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_read_a: rvalid=%b rdata=%h busy=%b, required 0/0/1", rvalid_a, rdata_a, busy_a);
        end
        vectors++;
        if (rdata_b !== 64'h0) begin
            miscompares++;
            $display("FAIL mid_read_b: rdata=%h, required 0", rdata_b);
        end
        sweep(n);
        vectors++;
        if (n + 1 != 16) begin
            miscompares++;
            $display("FAIL mid_read_sweep_len: busy for %0d cycles, required 16", n + 1);
        end
        zero_model();
        read_all();
    endtask

    task automatic test_busy_ignore();
        int n;
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 32'h5A000000 | 32'(i), 4'hF, 1'b0, 3'h0);
        rst = 1'b1;
        we = 1'b1; re = 1'b1; waddr = 4'd9; wdata = 32'hFFFFFFFF; wstrb = 4'hF; raddr = 3'd4;
        step();
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (busy_a !== 1'b1) break;
            n++;
            waddr = 4'($urandom_range(0, 15));
            raddr = 3'($urandom_range(0, 7));
            wdata = $urandom | 32'h1;
        end
        we = 1'b0; re = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL busy_ignore_len: busy for %0d cycles, required 16", n);
        end
        zero_model();
        read_all();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        waddr = '0; wstrb = '0; wdata = '0; raddr = '0;
        begin
            int n;
            step();
            step();
            rst = 1'b0;
            sweep(n);
        end
        zero_model();
        mon_en = 1'b1;

        test_reset();
        test_byte_strobe();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        test_busy_ignore();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
